// File: rtl/peripheral_axi4_pkg.sv
// ============================================================================
// Module      : peripheral_axi4_pkg
// Description : Shared AXI4 response/burst codes and FSM state types for the
//               AXI4 slave memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package peripheral_axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // WRAP and the reserved code step like INCR; the address wraps at memory depth.
  function automatic logic burst_advances(input logic [1:0] burst);
    case (burst)
      BURST_FIXED:            return 1'b0;
      BURST_INCR, BURST_WRAP: return 1'b1;
      default:                return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/peripheral_axi4_slave_ram.sv
// ============================================================================
// Module      : peripheral_axi4_slave_ram
// Description : 2**MEM_AW x 32-bit storage, byte-strobed synchronous write
//               port and asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral_axi4_slave_ram
  import peripheral_axi4_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [MEM_AW-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  input  logic [MEM_AW-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Asynchronous read: a same-cycle write is not yet visible.
  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/peripheral_axi4_slave_memory.sv
// ============================================================================
// Module      : peripheral_axi4_slave_memory
// Description : AXI4 slave backed by on-chip RAM; independent write/read FSMs.
//               Define PERIPHERAL_AXI4_SLAVE_RANGE_ERR_EN for SLVERR on
//               out-of-range burst start addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral_axi4_slave_memory
  import peripheral_axi4_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  awid,
  input  logic [31:0] awadr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wrdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  wr_state_t         r_wstate, w_wstate_nxt;
  logic [3:0]        r_awid, r_wlen, r_wcnt;
  logic [MEM_AW-1:0] r_waddr;
  logic [1:0]        r_wburst;
  logic              r_werr;

  rd_state_t         r_rstate, w_rstate_nxt;
  logic [3:0]        r_arid, r_rlen, r_rcnt;
  logic [MEM_AW-1:0] r_raddr;
  logic              r_rerr;

  logic        w_aw_hs, w_w_hs, w_w_last_beat;
  logic        w_ar_hs, w_r_hs, w_r_last_beat;
  logic        w_aw_err, w_ar_err, w_ram_we;
  logic [31:0] w_ram_rdata;

`ifdef PERIPHERAL_AXI4_SLAVE_RANGE_ERR_EN
  assign w_aw_err = |awadr[31:MEM_AW+2];
  assign w_ar_err = |araddr[31:MEM_AW+2];
`else
  assign w_aw_err = 1'b0;
  assign w_ar_err = 1'b0;
`endif

  logic w_unused;
  assign w_unused = &{1'b0, awsize, awlock, awcache, awprot, arsize, arlock,
                      arcache, arprot, wid, wlast, awadr[1:0], araddr[1:0],
                      awadr[31:MEM_AW+2], araddr[31:MEM_AW+2]};

  assign w_aw_hs       = awvalid && awready;
  assign w_w_hs        = wvalid && wready;
  assign w_w_last_beat = (r_wcnt == r_wlen);
  assign w_ar_hs       = arvalid && arready;
  assign w_r_hs        = rvalid && rready;
  assign w_r_last_beat = (r_rcnt == r_rlen);

  // ---------------- write channel ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_w_last_beat) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Burst length comes only from the beat counter; wlast is not consulted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_awid   <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_waddr  <= '0;
      r_wburst <= BURST_FIXED;
      r_werr   <= 1'b0;
    end else if (w_aw_hs) begin
      r_awid   <= awid;
      r_wlen   <= awlen;
      r_wcnt   <= '0;
      r_waddr  <= awadr[MEM_AW+1:2];
      r_wburst <= awburst;
      r_werr   <= w_aw_err;
    end else if (w_w_hs) begin
      if (!w_w_last_beat) r_wcnt <= r_wcnt + 4'd1;
      if (burst_advances(r_wburst)) r_waddr <= r_waddr + 1'b1;
    end
  end

  assign bid      = r_awid;
  assign bresp    = r_werr ? RESP_SLVERR : RESP_OKAY;
  assign w_ram_we = w_w_hs && !r_werr;

  // ---------------- read channel ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rlast        = 1'b0;
    rdata        = '0;
    case (r_rstate)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = w_r_last_beat;
        rdata  = r_rerr ? 32'd0 : w_ram_rdata;
        if (rready && w_r_last_beat) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_arid  <= '0;
      r_rlen  <= '0;
      r_rcnt  <= '0;
      r_raddr <= '0;
      r_rerr  <= 1'b0;
    end else if (w_ar_hs) begin
      r_arid  <= arid;
      r_rlen  <= arlen;
      r_rcnt  <= '0;
      r_raddr <= araddr[MEM_AW+1:2];
      r_rerr  <= w_ar_err;
    end else if (w_r_hs) begin
      if (!w_r_last_beat) r_rcnt <= r_rcnt + 4'd1;
      r_raddr <= r_raddr + 1'b1;
    end
  end

  assign rid   = r_arid;
  assign rresp = r_rerr ? RESP_SLVERR : RESP_OKAY;

  peripheral_axi4_slave_ram #(
    .MEM_AW (MEM_AW)
  ) u_ram (
    .clk     (aclk),
    .i_we    (w_ram_we),
    .i_waddr (r_waddr),
    .i_wdata (wrdata),
    .i_wstrb (wstrb),
    .i_raddr (r_raddr),
    .o_rdata (w_ram_rdata)
  );

endmodule

`default_nettype wire

// File: doc/peripheral_axi4_slave_memory.md
PERIPHERAL_AXI4_SLAVE_MEMORY -- requirements
Module: peripheral_axi4_slave_memory

Interface
REQ-001 Parameter MEM_AW, default 10, SHALL set memory depth as 2**MEM_AW 32-bit words.
REQ-002 Port list, clock and reset first:
- aclk  in  1  clock
- areset  in  1  reset, asynchronous, active-high
- awid/awadr/awlen/awsize/awburst/awlock/awcache/awprot  in  4/32/4/3/2/2/4/3  write address
- awvalid  in  1; awready  out  1
- wid/wrdata/wstrb/wlast/wvalid  in  4/32/4/1/1; wready  out  1
- bid/bresp/bvalid  out  4/2/1; bready  in  1
- arid/araddr/arlen/arsize/arlock/arcache/arprot/arvalid  in  4/32/4/3/2/4/3/1; arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1; rready  in  1
REQ-003 Single clock aclk; areset SHALL be asynchronous and active-high.
REQ-004 awlock/awcache/awprot/arlock/arcache/arprot/awsize/arsize/wid SHALL be accepted and ignored.

Function
REQ-005 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP; read FSM states SHALL be R_IDLE, R_DATA; the two FSMs SHALL run independently.
REQ-006 awready SHALL be 1 only in W_IDLE; awvalid&&awready SHALL latch awid, word address, awlen, awburst, clear the beat counter and move to W_DATA.
REQ-007 wready SHALL be 1 only in W_DATA, first asserted the cycle after the AW handshake.
REQ-008 Each wvalid&&wready beat SHALL write wrdata to the current word with byte enables wstrb.
REQ-009 Address update per beat: awburst 2'b00 (FIXED) holds; all other codes increment by one word, wrapping modulo depth.
REQ-010 Burst end SHALL be decided by the beat counter reaching awlen (awlen+1 beats); wlast SHALL NOT alter the count.
REQ-011 After the last W beat the FSM SHALL enter W_RESP; bvalid=1 from the next cycle, bid=latched awid, held stable until bready; bvalid&&bready SHALL return to W_IDLE.
REQ-012 arready SHALL be 1 only in R_IDLE; handshake SHALL latch arid, word address, arlen and enter R_DATA; all reads SHALL be INCR.
REQ-013 In R_DATA rvalid=1 starting the cycle after the AR handshake; rdata=mem[current word], rid=latched arid, rlast=1 on beat arlen; outputs SHALL hold while rready=0.
REQ-014 rvalid&&rready SHALL advance one word; on the rlast beat the FSM SHALL return to R_IDLE.
REQ-015 A read beat in the same cycle as a write to the same word SHALL return the pre-write data.
REQ-016 bresp/rresp SHALL be 2'b00 (OKAY) unless REQ-020 applies.

Reset
REQ-017 areset SHALL, asynchronously and at any time including mid-burst, force W_IDLE/R_IDLE, counters 0, awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bid/rid/bresp/rresp/rdata=0.
REQ-018 Memory contents SHALL NOT be cleared by reset.
REQ-019 The first AW/AR handshake SHALL be possible on the first rising edge after areset deasserts.

Configuration
REQ-020 With PERIPHERAL_AXI4_SLAVE_RANGE_ERR_EN defined, a burst whose start word address is >= 2**MEM_AW SHALL suppress all writes and return bresp=2'b10 (SLVERR), or return rresp=2'b10 with rdata=0 on every read beat; handshaking and beat counts are unchanged.
REQ-021 Without the macro, addresses SHALL be taken modulo depth and responses SHALL always be OKAY.

Structure
REQ-022 Package peripheral_axi4_pkg SHALL hold RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP constants and the write/read FSM state enums.
REQ-023 Storage SHALL be sub-module peripheral_axi4_slave_ram: one byte-strobed synchronous write port, one asynchronous read port.

Verification
REQ-024 Single write awadr=0x10, awlen=0, wrdata=0xDEADBEEF, wstrb=4'hF, then read araddr=0x10 -> bresp=0, rdata=0xDEADBEEF, rlast=1, rid=arid.
REQ-025 INCR write awlen=3 at 0x0 with data 1..4, bready held low 5 cycles -> bvalid stays 1, bid stable; a 4-beat read returns 1,2,3,4 with rlast only on beat 4.
REQ-026 FIXED write awlen=1 at 0x20, data 0xAAAAAAAA then 0x000000BB with wstrb=4'h1 -> read 0x20 returns 0xAAAAAABB.
REQ-027 Read burst with rready toggling 1/0 every cycle -> rdata/rid/rlast stable while stalled, no beat skipped or duplicated.
REQ-028 areset pulsed during beat 2 of a 4-beat write -> next cycle wready=0, bvalid=0, awready=1; a new write after reset completes normally.
REQ-029 Macro defined, MEM_AW=10, write to 0x00001000 -> bresp=2'b10 and word 0 unchanged; macro undefined -> bresp=0 and word 0 updated.
